rf_write_arbiter: RTL
=====================

// Module: rf_write_arbiter
// PURPOSE
//  Owns the single register_file write port (we3/a3/wd3) and shares it between the
//  in-order pipeline writeback stage and a long-latency unit (divider / load miss path).
//  Long-latency results are buffered in a small FIFO; a scoreboard of pending
//  destination registers drives a decode-stage RAW/WAW stall. Sits between WB and
//  register_file; its write-port outputs drive register_file directly.
// PARAMETERS
//  DEPTH      2   long-latency result FIFO entries (power of 2, >=2)
//  XLEN       32  data width
//  STARV_MAX  4   consecutive cycles a non-empty FIFO may lose arbitration before WB is held
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous reset, active low
//  wb_we        in   1        pipeline WB write request; no backpressure except via wb_hold
//  wb_rd        in   5        WB destination
//  wb_data      in   XLEN     WB data
//  mc_issue     in   1        long-latency op issued this cycle
//  mc_issue_rd  in   5        its destination
//  mc_valid     in   1        long-latency result valid
//  mc_rd        in   5        result destination
//  mc_data      in   XLEN     result data
//  mc_ready     out  1        FIFO can accept a result
//  chk_rs1      in   5        decode source 1
//  chk_rs2      in   5        decode source 2
//  chk_rd       in   5        decode destination
//  raw_stall    out  1        decode must stall (operand or dest pending)
//  wb_hold      out  1        WB stage must hold; its write is not performed this cycle
//  rf_we3       out  1        to register_file we3
//  rf_a3        out  5        to register_file a3
//  rf_wd3       out  XLEN     to register_file wd3
//  pending      out  32       scoreboard bitmap (bit 0 always 0)
//  fifo_count   out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst_n=0 at edge): FIFO empty, pending=0, starve_cnt=0. While rst_n=0 all outputs
//   forced low: rf_we3=0, mc_ready=0, raw_stall=0, wb_hold=0.
//  Accept: mc_ready = (fifo_count<DEPTH). Result taken on edge when mc_valid&&mc_ready.
//   mc_rd==0 results are accepted and discarded (not enqueued). Full: no accept, even if
//   the head drains that same cycle. Earliest write of an accepted result: next cycle.
//  Port select (combinational, same cycle):
//   wb_hold = (fifo_count!=0) && (starve_cnt>=STARV_MAX).
//   if wb_hold: port serves FIFO head; WB write is not performed (pipeline re-presents).
//   else if wb_we && wb_rd!=0: port serves WB.
//   else if fifo_count!=0: port serves FIFO head.  else rf_we3=0.
//   wb_we with wb_rd==0 never uses the port (x0 stays 0).
//  Dequeue on edge when head is served. starve_cnt: +1 (saturating) each edge where
//   FIFO non-empty and head not served; cleared to 0 on any dequeue or when FIFO empty.
//  Scoreboard: on edge, mc_issue && mc_issue_rd!=0 sets pending[mc_issue_rd]; dequeue
//   of head with rd r clears pending[r]. Set and clear of same r same edge -> set wins.
//   Issue to an already-pending rd is a protocol error (chk_rd stall prevents it); bit stays set.
//  raw_stall = pending[chk_rs1]|pending[chk_rs2]|pending[chk_rd], index 0 ignored; from
//   registered pending, so a register being drained this cycle still stalls 1 more cycle.
//  Simultaneous enqueue+dequeue (not full): count unchanged, order preserved.
//  Reset mid-operation: FIFO contents and pending bits lost; no write performed that cycle.
// TESTING
//  1 Reset: rst_n=0 2 cycles with wb_we=1,rd=5 -> rf_we3=0, pending=0, mc_ready=0.
//  2 WB only: wb_we=1,rd=1,data=DEADBEEF -> same cycle rf_we3=1,a3=1,wd3=DEADBEEF.
//  3 Scoreboard: mc_issue rd=2; chk_rs1=2 -> raw_stall=1 from next cycle; mc result rd=2
//    12345678 with WB idle -> written next cycle, raw_stall drops the cycle after.
//  4 Contention: WB writes every cycle, one FIFO entry rd=3 -> after STARV_MAX=4 losses
//    wb_hold=1, a3=3 written, WB write deferred one cycle, starve_cnt back to 0.
//  5 Full: two results enqueued while WB busy -> fifo_count=2, mc_ready=0, third held.
//  6 x0: wb rd=0 FFFFFFFF and mc rd=0 -> rf_we3=0, fifo_count=0, pending[0]=0.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the writeback stage, the long-latency unit, decode and
// the register file write port, as seen by rf_write_arbiter.
interface rf_write_arbiter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_hold;

  logic            mc_issue;
  logic [4:0]      mc_issue_rd;
  logic            mc_valid;
  logic [4:0]      mc_rd;
  logic [XLEN-1:0] mc_data;
  logic            mc_ready;

  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic [4:0]      chk_rd;
  logic            raw_stall;

  logic            rf_we3;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd3;
  logic [31:0]     pending;
  logic [CW-1:0]   fifo_count;

  modport master (
    output wb_we, wb_rd, wb_data, mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
           chk_rs1, chk_rs2, chk_rd,
    input  wb_hold, mc_ready, raw_stall, rf_we3, rf_a3, rf_wd3, pending, fifo_count
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
           chk_rs1, chk_rs2, chk_rd,
    output wb_hold, mc_ready, raw_stall, rf_we3, rf_a3, rf_wd3, pending, fifo_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between pipeline writeback and a buffered
// long-latency result stream; tracks pending destinations for decode RAW/WAW stalls.
module rf_write_arbiter #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STARV_MAX = 4
) (
  input logic                i_clk,
  input logic                i_rst_n,
  rf_write_arbiter_if.slave  io_bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARV_MAX + 1);

  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic [31:0]     r_pending;

  logic            w_nonempty;
  logic            w_hold;
  logic            w_wb_ok;
  logic            w_serve_fifo;
  logic            w_serve_wb;
  logic            w_ready;
  logic            w_enq;
  logic            w_deq;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic [CW-1:0]   w_count_d;
  logic [SW-1:0]   w_starve_d;
  logic [31:0]     w_pending_d;

  always_comb begin
    w_head_rd    = r_fifo_rd[r_rptr];
    w_head_data  = r_fifo_data[r_rptr];
    w_nonempty   = (r_count != '0);
    w_hold       = i_rst_n && w_nonempty && (r_starve >= SW'(STARV_MAX));
    w_wb_ok      = io_bus.wb_we && (io_bus.wb_rd != 5'd0);
    w_serve_fifo = i_rst_n && (w_hold || (!w_wb_ok && w_nonempty));
    w_serve_wb   = i_rst_n && !w_hold && w_wb_ok;
    // Full FIFO refuses results even when the head drains in the same cycle.
    w_ready      = i_rst_n && (r_count < CW'(DEPTH));
    w_enq        = io_bus.mc_valid && w_ready && (io_bus.mc_rd != 5'd0);
    w_deq        = w_serve_fifo;

    w_count_d = r_count;
    unique case ({w_enq, w_deq})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase

    w_starve_d = r_starve;
    if (w_deq || !w_nonempty) begin
      w_starve_d = '0;
    end else if (r_starve < SW'(STARV_MAX)) begin
      w_starve_d = r_starve + SW'(1);
    end

    // Clear first so a same-edge issue to the drained register keeps its bit set.
    w_pending_d = r_pending;
    if (w_deq) begin
      w_pending_d[w_head_rd] = 1'b0;
    end
    if (io_bus.mc_issue && (io_bus.mc_issue_rd != 5'd0)) begin
      w_pending_d[io_bus.mc_issue_rd] = 1'b1;
    end
    w_pending_d[0] = 1'b0;
  end

  always_comb begin
    io_bus.wb_hold    = w_hold;
    io_bus.mc_ready   = w_ready;
    io_bus.rf_we3     = w_serve_fifo || w_serve_wb;
    io_bus.rf_a3      = 5'd0;
    io_bus.rf_wd3     = '0;
    if (w_serve_fifo) begin
      io_bus.rf_a3  = w_head_rd;
      io_bus.rf_wd3 = w_head_data;
    end else if (w_serve_wb) begin
      io_bus.rf_a3  = io_bus.wb_rd;
      io_bus.rf_wd3 = io_bus.wb_data;
    end
    io_bus.raw_stall  = i_rst_n && (r_pending[io_bus.chk_rs1] || r_pending[io_bus.chk_rs2] ||
                                    r_pending[io_bus.chk_rd]);
    io_bus.pending    = r_pending;
    io_bus.fifo_count = r_count;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_pending <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count   <= w_count_d;
      r_starve  <= w_starve_d;
      r_pending <= w_pending_d;
    end
  end

  // Storage needs no reset; occupancy and pointers qualify every read.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_fifo_rd[r_wptr]   <= io_bus.mc_rd;
      r_fifo_data[r_wptr] <= io_bus.mc_data;
    end
  end
endmodule
